// File: rtl/fnd_controller.sv
// Four-digit common-anode 7-segment scanner for the stopwatch time outputs.
// Time inputs are captured once per scan frame so a frame never mixes two time values.
module fnd_controller #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int TICK_DIV = CLK_FREQ / SCAN_HZ;
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
    logic [1:0]       scanIdx_q, scanIdx_d;
    logic [6:0]       msec_q, msec_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             mode_q, mode_d;
    logic [3:0]       com_q, com_d;
    logic [7:0]       data_q, data_d;

    logic       tick, frameStart, modeEff, digitBad;
    logic [1:0] nextIdx;
    logic [6:0] msecEff, loVal, loLim;
    logic [5:0] hiVal, hiLim;
    logic [3:0] digit;
    logic [7:0] seg;

    function automatic logic [7:0] segCode(input logic [3:0] d);
        case (d)
            4'd0:    segCode = 8'hC0;
            4'd1:    segCode = 8'hF9;
            4'd2:    segCode = 8'hA4;
            4'd3:    segCode = 8'hB0;
            4'd4:    segCode = 8'h99;
            4'd5:    segCode = 8'h92;
            4'd6:    segCode = 8'h82;
            4'd7:    segCode = 8'hF8;
            4'd8:    segCode = 8'h80;
            4'd9:    segCode = 8'h90;
            default: segCode = 8'hFF;
        endcase
    endfunction

    always_comb begin
        tick       = (tickCnt_q == TICK_MAX);
        frameStart = tick && (scanIdx_q == 2'd3);
        nextIdx    = scanIdx_q + 2'd1;

        // At the frame-start edge the live inputs bypass the snapshot so digit 0 is already current
        msecEff = frameStart ? msec     : msec_q;
        modeEff = frameStart ? sel_mode : mode_q;
        loVal   = modeEff ? {1'b0, (frameStart ? min : min_q)}  : msecEff;
        loLim   = modeEff ? 7'd60 : 7'd100;
        hiVal   = modeEff ? {1'b0, (frameStart ? hour : hour_q)} : (frameStart ? sec : sec_q);
        hiLim   = modeEff ? 6'd24 : 6'd60;

        digit    = 4'd0;
        digitBad = 1'b0;
        case (nextIdx)
            2'd0: begin digit = 4'(loVal % 7'd10); digitBad = (loVal >= loLim); end
            2'd1: begin digit = 4'(loVal / 7'd10); digitBad = (loVal >= loLim); end
            2'd2: begin digit = 4'(hiVal % 6'd10); digitBad = (hiVal >= hiLim); end
            default: begin digit = 4'(hiVal / 6'd10); digitBad = (hiVal >= hiLim); end
        endcase

        seg = digitBad ? 8'hBF : segCode(digit);
        if ((nextIdx == 2'd2) && (msecEff < 7'd50)) begin
            seg[7] = 1'b0;
        end

        tickCnt_d = tick ? '0 : tickCnt_q + CNT_W'(1);
        scanIdx_d = scanIdx_q;
        com_d     = com_q;
        data_d    = data_q;
        msec_d    = msec_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        mode_d    = mode_q;

        if (tick) begin
            scanIdx_d = nextIdx;
            com_d     = ~(4'b0001 << nextIdx);
            data_d    = seg;
        end
        if (frameStart) begin
            msec_d = msec;
            sec_d  = sec;
            min_d  = min;
            hour_d = hour;
            mode_d = sel_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tickCnt_q <= '0;
            scanIdx_q <= 2'd3;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            mode_q    <= 1'b0;
            com_q     <= 4'b1111;
            data_q    <= 8'hFF;
        end else begin
            tickCnt_q <= tickCnt_d;
            scanIdx_q <= scanIdx_d;
            msec_q    <= msec_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            mode_q    <= mode_d;
            com_q     <= com_d;
            data_q    <= data_d;
        end
    end

    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_controller.sv
// Bench for fnd_controller: directed display scenarios followed by random time values,
// all checked every clock against a frame-level reference model.
module tb_fnd_controller;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel_mode = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edges since reset release, current digit and the frame's captured values
    int         mEdges = 0;
    int         mIdx = 3;
    bit         mTick = 0;
    int         sMsec = 0, sSec = 0, sMin = 0, sHour = 0, sMode = 0;
    logic [3:0] eCom = 4'hF;
    logic [7:0] eData = 8'hFF;
    logic [7:0] segTab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    fnd_controller #(.CLK_FREQ(100), .SCAN_HZ(25)) dut (
        .clk(clk), .rst(rst), .sel_mode(sel_mode), .msec(msec), .sec(sec),
        .min(min), .hour(hour), .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    function automatic logic [7:0] expDigit(input int k);
        int lo, loLim, hi, hiLim, v, lim, d;
        logic [7:0] s;
        lo    = sMode ? sMin : sMsec;
        loLim = sMode ? 60 : 100;
        hi    = sMode ? sHour : sSec;
        hiLim = sMode ? 24 : 60;
        v   = (k < 2) ? lo : hi;
        lim = (k < 2) ? loLim : hiLim;
        d   = (k % 2 == 0) ? v % 10 : v / 10;
        s   = (v >= lim) ? 8'hBF : segTab[d];
        if (k == 2 && sMsec < 50) s = s & 8'h7F;
        return s;
    endfunction

    task automatic modelEdge();
        mTick = 0;
        if (!rst) begin
            mEdges = 0; mIdx = 3;
            sMsec = 0; sSec = 0; sMin = 0; sHour = 0; sMode = 0;
            eCom = 4'hF; eData = 8'hFF;
        end else begin
            mEdges++;
            if (mEdges % TICK_DIV == 0) begin
                mTick = 1;
                mIdx  = (mIdx + 1) % 4;
                if (mIdx == 0) begin
                    sMsec = msec; sSec = sec; sMin = min; sHour = hour; sMode = sel_mode;
                end
                eCom  = ~(4'b0001 << mIdx);
                eData = expDigit(mIdx);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("com", {4'h0, fnd_com}, {4'h0, eCom});
        checkOutput("data", fnd_data, eData);
        checkOutput("onehot", 8'($countones(~fnd_com) <= 1), 8'd1);
    endtask

    task automatic runToIdx(input int k);
        bit hit = 0;
        for (int i = 0; i < 5 * TICK_DIV && !hit; i++) begin
            applyStimulus();
            hit = mTick && (mIdx == k);
        end
        vectors++;
        assert (hit) else begin
            miscompares++;
            $error("[TB] FAIL runToIdx observed=timeout expected=digit%0d", k);
        end
    endtask

    task automatic expectDigit(input string tag, input int k, input logic [3:0] com,
                               input logic [7:0] data);
        runToIdx(k);
        checkOutput({tag, "_com"}, {4'h0, fnd_com}, {4'h0, com});
        checkOutput({tag, "_data"}, fnd_data, data);
    endtask

    initial begin
        // Reset held for three clocks blanks the display
        rst = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("rst_com", {4'h0, fnd_com}, 8'h0F);
        checkOutput("rst_data", fnd_data, 8'hFF);

        // First change after release lands on edge TICK_DIV
        rst = 1'b1;
        repeat (TICK_DIV - 1) applyStimulus();
        checkOutput("pre_tick_data", fnd_data, 8'hFF);
        applyStimulus();
        checkOutput("first_com", {4'h0, fnd_com}, 8'h0E);
        checkOutput("first_data", fnd_data, 8'hC0);

        // Mode 0, sec=42 msec=37
        sec = 6'd42; msec = 7'd37;
        expectDigit("m0_d0", 0, 4'b1110, 8'hF8);
        expectDigit("m0_d1", 1, 4'b1101, 8'hB0);
        expectDigit("m0_d2", 2, 4'b1011, 8'h24);
        expectDigit("m0_d3", 3, 4'b0111, 8'h99);

        // Mode 1, hour=23 min=5 msec=80
        sel_mode = 1'b1; hour = 5'd23; min = 6'd5; msec = 7'd80;
        expectDigit("m1_d0", 0, 4'b1110, 8'h92);
        expectDigit("m1_d1", 1, 4'b1101, 8'hC0);
        expectDigit("m1_d2", 2, 4'b1011, 8'hB0);
        expectDigit("m1_d3", 3, 4'b0111, 8'hA4);

        // Mid-frame change of sec and mode is deferred to the next frame
        sel_mode = 1'b0; sec = 6'd12; msec = 7'd10;
        runToIdx(0);
        runToIdx(1);
        sec = 6'd34; sel_mode = 1'b1;
        expectDigit("snap_d2", 2, 4'b1011, 8'h24);
        expectDigit("snap_d3", 3, 4'b0111, 8'hF9);
        sel_mode = 1'b0;
        runToIdx(0);
        expectDigit("snap_new_d2", 2, 4'b1011, 8'h19);
        expectDigit("snap_new_d3", 3, 4'b0111, 8'hB0);

        // Out-of-range pairs show dashes
        msec = 7'd110; sec = 6'd60;
        expectDigit("oor_d0", 0, 4'b1110, 8'hBF);
        expectDigit("oor_d1", 1, 4'b1101, 8'hBF);
        expectDigit("oor_d2", 2, 4'b1011, 8'hBF);
        expectDigit("oor_d3", 3, 4'b0111, 8'hBF);

        // Reset while digit 2 is shown
        msec = 7'd5; sec = 6'd9;
        runToIdx(2);
        rst = 1'b0;
        applyStimulus();
        checkOutput("midrst_com", {4'h0, fnd_com}, 8'h0F);
        checkOutput("midrst_data", fnd_data, 8'hFF);
        rst = 1'b1;
        repeat (TICK_DIV) applyStimulus();
        checkOutput("restart_com", {4'h0, fnd_com}, 8'h0E);
        checkOutput("restart_data", fnd_data, 8'h92);

        // Random time values, occasionally out of range, changed at random points in frames
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                sel_mode = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    msec = 7'($urandom_range(0, 127));
                    sec  = 6'($urandom_range(0, 63));
                    min  = 6'($urandom_range(0, 63));
                    hour = 5'($urandom_range(0, 31));
                end else begin
                    msec = 7'($urandom_range(0, 99));
                    sec  = 6'($urandom_range(0, 59));
                    min  = 6'($urandom_range(0, 59));
                    hour = 5'($urandom_range(0, 23));
                end
            end
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            applyStimulus();
            rst = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fnd_controller.md
Name: fnd_controller

Overview:
- Display-side consumer of the stopwatch time outputs: reads msec/sec/min/hour and drives a 4-digit, common-anode 7-segment (FND) display by time-multiplexed digit scanning.
- sel_mode selects the displayed pair: 0 shows sec.msec, 1 shows hour.min.
- Inputs are snapshotted once per scan frame so a frame never mixes two time values.
- Sits beside the stopwatch inside the board top; pure reader, no feedback to the stopwatch.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz; TICK_DIV = CLK_FREQ/SCAN_HZ clocks per digit (must be ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- sel_mode  input  1  0: sec/msec, 1: hour/min.
- msec  input  7  hundredths of a second, valid 0..99.
- sec  input  6  seconds, valid 0..59.
- min  input  6  minutes, valid 0..59.
- hour  input  5  hours, valid 0..23.
- fnd_com  output  4  digit enables, active-low; bit0 = rightmost digit.
- fnd_data  output  8  segments, active-low; [7]=dp, [6:0]=g..a.

Behaviour:
- Reset (rst=0 at a clock edge): tick counter=0, scan index=3, snapshot registers (msec, sec, min, hour, mode) = 0, fnd_com=4'b1111 (all off), fnd_data=8'hFF.
- Tick counter counts 0..TICK_DIV-1 and wraps. The tick is the cycle where count = TICK_DIV-1. The first tick after reset release is at clock edge TICK_DIV.
- On each tick, scan index advances (3→0→1→2→3). fnd_com/fnd_data are registered and change only at a tick edge. Between ticks they hold.
- Frame snapshot: on the tick where the index goes 3→0, all five inputs are captured. The outputs driven at that same edge already use the newly captured values; the inputs feed the digit decode directly on that edge.
  - Input or sel_mode changes take effect only at the next 3→0 tick.
- Digit mapping, using snapshot values:
  - mode 0: digit3 = sec/10, digit2 = sec%10, digit1 = msec/10, digit0 = msec%10.
  - mode 1: digit3 = hour/10, digit2 = hour%10, digit1 = min/10, digit0 = min%10.
- fnd_com for index k: only bit k low (k=0 → 4'b1110, k=3 → 4'b0111). Never more than one digit enabled.
- Segment codes [6:0] with dp off (bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Out-of-range pair value (msec ≥100, or sec/min ≥60, hour ≥24): both digits of that pair show dash 8'hBF. No clamping or wrapping of the value.
- Decimal point: lit (bit7=0) only on digit2, and only when snapshot msec < 50, in both modes. This gives a 1 Hz blink while the stopwatch runs; the dp stays steady while it is stopped.
- Reset mid-frame: all state returns to reset values on that edge, and the display blanks until the next tick.
- Counter widths are sized for TICK_DIV-1. No other arithmetic overflow is possible.

Test Plan:
- Setup for all cases: CLK_FREQ=100, SCAN_HZ=25 (TICK_DIV=4).
- Reset: hold rst=0 for 3 clocks → fnd_com=1111, fnd_data=FF. Release → first change at edge 4: fnd_com=1110, fnd_data=C0 (snapshot of zero inputs).
- Scan order, mode 0, sec=42, msec=37: over one frame → (1110,F8), (1101,B0), (1011,A4 with dp → 24), (0111,99). Only one fnd_com bit is low at any time.
- Mode 1, hour=23, min=5, msec=80: frame shows (1110,92), (1101,C0), (1011,B0 with dp off), (0111,A4).
- Snapshot: change sec from 12 to 34 while index=1 → digits 2/3 of the current frame still show 2/1. The new value appears only after the next 3→0 tick. A sel_mode toggle mid-frame is handled the same way.
- Out of range: msec=110 → digits 1 and 0 both BF. sec=60 in mode 0 → digits 3 and 2 both BF.
- Reset mid-operation: assert rst during index=2 → the next edge gives fnd_com=1111, fnd_data=FF, and the scan restarts at digit 0 after TICK_DIV clocks.
